game_sequencer: RTL and testbench
=================================

// Module: game_sequencer
// PURPOSE
//  Top-level game controller for Flappy Bird. Sits between the Basys3 buttons and the game datapath.
//  Debounces flap/pause/restart buttons and owns the IDLE/PLAY/PAUSE/OVER state machine.
//  Generates the game tick enable, which replaces the divided game clock, and the flap and game_rst pulses.
//  Keeps current/highest score; feeds the game datapath, vga640x480 and segdisplay.
// PARAMETERS
//  CLK_HZ      100_000_000  clk frequency
//  TICK_HZ     50           game tick rate; DIV = CLK_HZ/TICK_HZ
//  DB_CYCLES   1_000_000    stable cycles for a debounced level change (10 ms)
//  HOLD_TICKS  100          ticks spent in OVER before restart is accepted
//  SCORE_W     10           score width
// PORTS
//  clk            in   1        master clock, 100 MHz
//  clr            in   1        asynchronous reset, active-low (clr=0 resets)
//  btn_flap       in   1        raw flap button, asynchronous
//  btn_pause      in   1        raw pause button, asynchronous
//  btn_restart    in   1        raw restart button, asynchronous
//  collision      in   1        level from datapath, clk domain
//  pipe_passed    in   1        1-cycle pulse from datapath, clk domain
//  tick           out  1        1-cycle game-step enable, PLAY only
//  flap           out  1        1-cycle pulse, coincident with tick
//  game_rst       out  1        1-cycle datapath reinit pulse
//  state          out  2        00 IDLE, 01 PLAY, 10 PAUSE, 11 OVER
//  current_score  out  SCORE_W  score of the running game
//  highest_score  out  SCORE_W  best score since clr
// BEHAVIOUR
//  Reset values: state=IDLE; tick, flap, game_rst=0; both scores=0; all counters and debounce outputs=0.
//  Buttons: 2-FF synchroniser, then debounce counter.
//   - Debounced level changes only after DB_CYCLES consecutive equal samples.
//   - press = 1-cycle rising-edge pulse of the debounced level.
//  Divider: cnt runs 0..DIV-1 in every state. wrap=1 when cnt==DIV-1.
//   - tick = wrap & (state==PLAY), registered.
//  flap_pending:
//   - Set by press_flap in PLAY.
//   - When tick fires: flap=1 in the same cycle, pending clears.
//   - Presses between ticks merge into one flap. If a press and a tick occur together, the press is serviced at that tick.
//   - Pending clears on leaving PLAY.
//  FSM (priority top-down each cycle):
//   - press_restart, any state -> IDLE; current_score=0; highest_score kept; pending cleared.
//   - IDLE:  press_flap -> PLAY; game_rst=1 for 1 cycle; current_score=0.
//   - PLAY:  collision -> OVER; else press_pause -> PAUSE; pipe_passed -> current_score+1, saturating at 2^SCORE_W-1.
//   - PAUSE: press_pause -> PLAY. flap ignored, no ticks, cnt keeps running.
//   - OVER:
//     - On entry: highest_score = max(highest_score, current_score); hold counter cleared.
//     - Hold counter counts wraps up to HOLD_TICKS.
//     - press_flap with hold==HOLD_TICKS -> PLAY, with game_rst and score clear.
//     - Earlier presses are ignored.
//  Simultaneous events:
//   - collision + pipe_passed: collision wins; score is not incremented.
//   - collision + press_pause: OVER.
//   - restart beats everything.
//  Latency: press reaches FSM DB_CYCLES+3 cycles after a stable edge. FSM outputs are registered, +1 cycle.
//  clr mid-game: everything returns to reset values immediately, including highest_score.
// STRUCTURE
//  Shared package: state encodings (ST_IDLE..ST_OVER), DIV = CLK_HZ/TICK_HZ, SCORE_MAX.
//  Sub-module btn_debounce (sync + counter + edge pulse), instantiated 3x. FSM, divider and scores live in this top.
// TESTING (CLK_HZ=1000, TICK_HZ=100 -> DIV=10, DB_CYCLES=3, HOLD_TICKS=2, SCORE_W=4)
//  1 clr low then high; glitch btn_flap 2 cycles -> state stays 00, no game_rst.
//  2 Hold btn_flap 6 cycles in IDLE -> one game_rst pulse; state=01; tick every 10 cycles; flap=1 only with next tick.
//  3 In PLAY, 20 pipe_passed pulses -> current_score saturates at 15.
//     Then collision + pipe_passed same cycle -> state=11, score stays 15, highest=15.
//  4 In PLAY, press pause -> state=10, no tick for 50 cycles, flap ignored.
//     Press pause again -> 01; ticks resume at the next wrap.
//  5 In OVER, press flap after 1 tick -> ignored.
//     Press after 2 ticks -> state=01, game_rst, current_score=0, highest unchanged.
//  6 Press restart in PLAY with score 7 -> state=00, current=0, highest kept.
//     Then clr low mid-PLAY -> all outputs 0.

Source files
------------

// File: rtl/game_sequencer_pkg.sv
// Shared definitions for the Flappy Bird game controller: state encoding,
// tick divider ratio and score ceiling.
package game_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PLAY  = 2'b01,
        ST_PAUSE = 2'b10,
        ST_OVER  = 2'b11
    } state_t;

    // Clock cycles per game tick.
    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // Largest value a score of the given width can hold.
    function automatic int unsigned score_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Board/datapath side bundle of the game controller. The slave modport is the
// controller's view; master is the buttons plus datapath driving it.
interface game_sequencer_if #(
    parameter int unsigned SCORE_W = 10
);
    import game_sequencer_pkg::*;

    logic               btn_flap;
    logic               btn_pause;
    logic               btn_restart;
    logic               collision;
    logic               pipe_passed;
    logic               tick;
    logic               flap;
    logic               game_rst;
    state_t             state;
    logic [SCORE_W-1:0] current_score;
    logic [SCORE_W-1:0] highest_score;

    modport master (
        output btn_flap, btn_pause, btn_restart, collision, pipe_passed,
        input  tick, flap, game_rst, state, current_score, highest_score
    );

    modport slave (
        input  btn_flap, btn_pause, btn_restart, collision, pipe_passed,
        output tick, flap, game_rst, state, current_score, highest_score
    );

endinterface

// File: rtl/game_sequencer_btn_debounce.sv
// Button conditioner: two-flop synchroniser, stable-count debouncer and a
// one-cycle pulse on each rising edge of the debounced level.
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic clr,
    input  logic btn_i,
    output logic press_o
);
    localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             level_prev_q;
    logic             press_q;

    // Bring the asynchronous button into the clk domain.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

    // Flip the debounced level only after DB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else if (sync2_q == level_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
            cnt_q   <= '0;
            level_q <= sync2_q;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Registered rising-edge pulse of the debounced level.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            level_prev_q <= 1'b0;
            press_q      <= 1'b0;
        end else begin
            level_prev_q <= level_q;
            press_q      <= level_q & ~level_prev_q;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/game_sequencer.sv
// Flappy Bird game controller: button conditioning, IDLE/PLAY/PAUSE/OVER
// state machine, game tick enable, flap/game_rst pulses and score keeping.
module game_sequencer #(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned TICK_HZ    = 50,
    parameter int unsigned DB_CYCLES  = 1_000_000,
    parameter int unsigned HOLD_TICKS = 100,
    parameter int unsigned SCORE_W    = 10
) (
    input  logic             clk,
    input  logic             clr,
    game_sequencer_if.slave  bus
);
    import game_sequencer_pkg::*;

    localparam int unsigned DIV    = calc_div(CLK_HZ, TICK_HZ);
    localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned HOLD_W = $clog2(HOLD_TICKS + 1);
    localparam logic [SCORE_W-1:0] SCORE_TOP = SCORE_W'(score_max(SCORE_W));

    // Score increment that sticks at the top value instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s == SCORE_TOP) ? s : s + 1'b1;
    endfunction

    function automatic logic [SCORE_W-1:0] score_hi(input logic [SCORE_W-1:0] a,
                                                    input logic [SCORE_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic press_flap;
    logic press_pause;
    logic press_restart;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_flap (
        .clk(clk), .clr(clr), .btn_i(bus.btn_flap), .press_o(press_flap)
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_pause (
        .clk(clk), .clr(clr), .btn_i(bus.btn_pause), .press_o(press_pause)
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_restart (
        .clk(clk), .clr(clr), .btn_i(bus.btn_restart), .press_o(press_restart)
    );

    logic [DIV_W-1:0]   cnt_q;
    logic               wrap;
    state_t             state_q;
    logic               tick_q;
    logic               flap_q;
    logic               game_rst_q;
    logic               pending_q;
    logic [HOLD_W-1:0]  hold_q;
    logic [SCORE_W-1:0] cur_q;
    logic [SCORE_W-1:0] high_q;

    logic tick_d;
    logic flap_d;
    logic pending_d;
    logic leave_play;

    assign wrap       = (cnt_q == DIV_W'(DIV - 1));
    assign tick_d     = wrap & (state_q == ST_PLAY);
    // A press landing on the tick itself is serviced by that tick.
    assign flap_d     = tick_d & (pending_q | press_flap);
    assign leave_play = press_restart | bus.collision | press_pause;
    // Pending flap survives only while the game stays in PLAY and no tick consumes it.
    assign pending_d  = ((state_q == ST_PLAY) && !leave_play && !tick_d) ? (pending_q | press_flap) : 1'b0;

    // Free-running tick divider, counting in every state.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= wrap ? '0 : cnt_q + 1'b1;
        end
    end

    // Game state machine with registered tick/flap/game_rst and scores; restart has top priority.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= ST_IDLE;
            tick_q     <= 1'b0;
            flap_q     <= 1'b0;
            game_rst_q <= 1'b0;
            pending_q  <= 1'b0;
            hold_q     <= '0;
            cur_q      <= '0;
            high_q     <= '0;
        end else begin
            tick_q     <= tick_d;
            flap_q     <= flap_d;
            pending_q  <= pending_d;
            game_rst_q <= 1'b0;
            if (press_restart) begin
                state_q <= ST_IDLE;
                cur_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (press_flap) begin
                            state_q    <= ST_PLAY;
                            game_rst_q <= 1'b1;
                            cur_q      <= '0;
                        end
                    end
                    ST_PLAY: begin
                        if (bus.collision) begin
                            state_q <= ST_OVER;
                            high_q  <= score_hi(high_q, cur_q);
                            hold_q  <= '0;
                        end else begin
                            if (press_pause) state_q <= ST_PAUSE;
                            if (bus.pipe_passed) cur_q <= sat_inc(cur_q);
                        end
                    end
                    ST_PAUSE: begin
                        if (press_pause) state_q <= ST_PLAY;
                    end
                    ST_OVER: begin
                        if (press_flap && hold_q == HOLD_W'(HOLD_TICKS)) begin
                            state_q    <= ST_PLAY;
                            game_rst_q <= 1'b1;
                            cur_q      <= '0;
                        end else if (wrap && hold_q != HOLD_W'(HOLD_TICKS)) begin
                            hold_q <= hold_q + 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.tick          = tick_q;
    assign bus.flap          = flap_q;
    assign bus.game_rst      = game_rst_q;
    assign bus.state         = state_q;
    assign bus.current_score = cur_q;
    assign bus.highest_score = high_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed game scenarios followed by random button,
// collision and pipe traffic, all scored against a cycle-level rule model.
module tb_game_sequencer;
    import game_sequencer_pkg::*;

    localparam int CLK_HZ  = 1000;
    localparam int TICK_HZ = 100;
    localparam int DB      = 3;
    localparam int HOLD    = 2;
    localparam int SW      = 4;
    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int SMAX    = (1 << SW) - 1;

    logic clk = 1'b0;
    logic clr = 1'b1;

    game_sequencer_if #(.SCORE_W(SW)) bus ();

    game_sequencer #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DB_CYCLES(DB),
        .HOLD_TICKS(HOLD), .SCORE_W(SW)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int n_tick, n_flap, n_grst;

    // reference model state
    int raw_h [3][DB+2];
    int lvl [3];
    int rd1 [3];
    int rd2 [3];
    int m_st, m_cur, m_high, m_pend, m_hold, m_e;
    int e_tick, e_flap, e_grst;

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < DB + 2; i++) raw_h[b][i] = 0;
            lvl[b] = 0; rd1[b] = 0; rd2[b] = 0;
        end
        m_st = 0; m_cur = 0; m_high = 0; m_pend = 0; m_hold = 0; m_e = 0;
        e_tick = 0; e_flap = 0; e_grst = 0;
    endtask

    // One clock edge of the rule model, using inputs present at that edge.
    task automatic model_edge();
        int raw [3];
        int pr [3];
        int same, rise, wrap, nst, coll, pipe;
        raw[0] = int'(bus.btn_flap);
        raw[1] = int'(bus.btn_pause);
        raw[2] = int'(bus.btn_restart);
        coll = int'(bus.collision);
        pipe = int'(bus.pipe_passed);
        if (!clr) begin
            model_reset();
            return;
        end
        // button: level flips once the synchronised input held a new value for DB samples;
        // the press reaches the state machine two edges after the flip
        for (int b = 0; b < 3; b++) begin
            for (int i = DB + 1; i > 0; i--) raw_h[b][i] = raw_h[b][i-1];
            raw_h[b][0] = raw[b];
            same = 1;
            for (int i = 2; i < 2 + DB; i++) if (raw_h[b][i] != raw_h[b][2]) same = 0;
            rise = 0;
            if (same == 1 && raw_h[b][2] != lvl[b]) begin
                lvl[b] = raw_h[b][2];
                rise = lvl[b];
            end
            pr[b] = rd2[b];
            rd2[b] = rd1[b];
            rd1[b] = rise;
        end
        wrap = ((m_e % DIV) == DIV - 1) ? 1 : 0;
        m_e++;
        e_tick = (wrap == 1 && m_st == 1) ? 1 : 0;
        e_flap = (e_tick == 1 && (m_pend == 1 || pr[0] == 1)) ? 1 : 0;
        e_grst = 0;
        nst = m_st;
        if (pr[2] == 1) begin
            nst = 0;
            m_cur = 0;
        end else begin
            case (m_st)
                0: if (pr[0] == 1) begin nst = 1; e_grst = 1; m_cur = 0; end
                1: begin
                    if (coll == 1) begin
                        nst = 3;
                        if (m_cur > m_high) m_high = m_cur;
                        m_hold = 0;
                    end else begin
                        if (pr[1] == 1) nst = 2;
                        if (pipe == 1 && m_cur < SMAX) m_cur = m_cur + 1;
                    end
                end
                2: if (pr[1] == 1) nst = 1;
                default: begin
                    if (pr[0] == 1 && m_hold == HOLD) begin
                        nst = 1; e_grst = 1; m_cur = 0;
                    end else if (wrap == 1 && m_hold < HOLD) begin
                        m_hold++;
                    end
                end
            endcase
        end
        if (pr[2] == 0 && m_st == 1 && nst == 1 && e_tick == 0)
            m_pend = (m_pend == 1 || pr[0] == 1) ? 1 : 0;
        else
            m_pend = 0;
        m_st = nst;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("tick", int'(bus.tick), e_tick);
        chk("flap", int'(bus.flap), e_flap);
        chk("game_rst", int'(bus.game_rst), e_grst);
        chk("state", int'(bus.state), m_st);
        chk("current_score", int'(bus.current_score), m_cur);
        chk("highest_score", int'(bus.highest_score), m_high);
        if (bus.flap) chk("flap_with_tick", int'(bus.tick), 1);
        n_tick += int'(bus.tick);
        n_flap += int'(bus.flap);
        n_grst += int'(bus.game_rst);
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: bus.btn_flap = v;
            1: bus.btn_pause = v;
            default: bus.btn_restart = v;
        endcase
    endtask

    // Hold a button long enough to register, then release and let it settle.
    task automatic push(input int b, input int len);
        set_btn(b, 1'b1);
        run(len);
        set_btn(b, 1'b0);
        run(8);
    endtask

    int rem [3];

    initial begin
        bus.btn_flap = 0; bus.btn_pause = 0; bus.btn_restart = 0;
        bus.collision = 0; bus.pipe_passed = 0;
        model_reset();
        #1 clr = 1'b0;
        run(3);
        chk("rst_state", int'(bus.state), 0);
        chk("rst_high", int'(bus.highest_score), 0);
        clr = 1'b1;

        // short glitch on flap is filtered
        n_grst = 0;
        set_btn(0, 1'b1); run(2); set_btn(0, 1'b0); run(10);
        chk("glitch_state", int'(bus.state), 0);
        chk("glitch_grst", n_grst, 0);

        // proper flap press starts the game
        n_grst = 0;
        push(0, 6);
        chk("start_state", int'(bus.state), 1);
        chk("start_grst", n_grst, 1);
        n_tick = 0;
        run(40);
        chk("tick_per_40", n_tick, 4);
        n_flap = 0;
        push(0, 6); run(10);
        chk("one_flap", n_flap, 1);

        // score saturates, then collision beats pipe_passed
        repeat (20) begin
            bus.pipe_passed = 1; run(1);
            bus.pipe_passed = 0; run(1);
        end
        chk("sat_score", int'(bus.current_score), 15);
        bus.collision = 1; bus.pipe_passed = 1; run(1);
        bus.collision = 0; bus.pipe_passed = 0;
        chk("over_state", int'(bus.state), 3);
        chk("over_score", int'(bus.current_score), 15);
        chk("over_high", int'(bus.highest_score), 15);

        // early flap in OVER ignored, later one restarts play
        push(0, 6);
        chk("early_flap_state", int'(bus.state), 3);
        run(25);
        n_grst = 0;
        push(0, 6);
        chk("replay_state", int'(bus.state), 1);
        chk("replay_score", int'(bus.current_score), 0);
        chk("replay_high", int'(bus.highest_score), 15);
        chk("replay_grst", n_grst, 1);

        // pause freezes ticks and ignores flap
        push(1, 6);
        chk("pause_state", int'(bus.state), 2);
        n_tick = 0; n_flap = 0;
        push(0, 6); run(36);
        chk("pause_ticks", n_tick, 0);
        chk("pause_flaps", n_flap, 0);
        push(1, 6);
        chk("resume_state", int'(bus.state), 1);
        n_tick = 0;
        run(20);
        chk("resume_ticks", (n_tick >= 2) ? 1 : 0, 1);

        // restart keeps best score, clr wipes everything
        repeat (7) begin
            bus.pipe_passed = 1; run(1);
            bus.pipe_passed = 0; run(1);
        end
        chk("score7", int'(bus.current_score), 7);
        push(2, 6);
        chk("restart_state", int'(bus.state), 0);
        chk("restart_score", int'(bus.current_score), 0);
        chk("restart_high", int'(bus.highest_score), 15);
        push(0, 6);
        chk("play_again", int'(bus.state), 1);
        run(5);
        #2 clr = 1'b0;
        #1;
        chk("clr_state", int'(bus.state), 0);
        chk("clr_tick", int'(bus.tick), 0);
        chk("clr_flap", int'(bus.flap), 0);
        chk("clr_grst", int'(bus.game_rst), 0);
        chk("clr_cur", int'(bus.current_score), 0);
        chk("clr_high", int'(bus.highest_score), 0);
        run(2);
        clr = 1'b1;

        // random traffic against the model
        for (int b = 0; b < 3; b++) rem[b] = 0;
        repeat (4000) begin
            for (int b = 0; b < 3; b++) begin
                if (rem[b] > 0) begin
                    rem[b]--;
                    if (rem[b] == 0) set_btn(b, 1'b0);
                end else if ($urandom_range(0, (b == 2) ? 199 : 29) == 0) begin
                    rem[b] = $urandom_range(1, 9);
                    set_btn(b, 1'b1);
                end
            end
            bus.collision   = ($urandom_range(0, 49) == 0);
            bus.pipe_passed = ($urandom_range(0, 5) == 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
